sprite_addr_seq: RTL and testbench

//  Producer side of the sprite ROM interface: turns VGA raster coordinates plus sprite

---
 rtl/sprite_addr_seq.sv | 169 ++++++++++++++++
 tb/tb_sprite_addr_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_addr_seq.sv
// Sprite ROM address sequencer: maps raster coordinates to a registered ROM address and
// sprite_on flag, and steps animation frames on vsync falls so frames never tear.
module sprite_addr_seq #(
  parameter int SPR_W  = 96,
  parameter int SPR_H  = 112,
  parameter int FRAMES = 4,
  parameter int HOLD   = 6,
  parameter int ADDR_W = 16
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic [9:0]               draw_x,
  input  logic [9:0]               draw_y,
  input  logic [9:0]               pos_x,
  input  logic [9:0]               pos_y,
  input  logic                     mirror,
  input  logic                     play,
  input  logic                     loop,
  output logic [ADDR_W-1:0]        rom_address,
  output logic                     sprite_on,
  output logic [(FRAMES > 1 ? $clog2(FRAMES) : 1)-1:0] frame,
  output logic                     busy,
  output logic                     done
);

  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD - 1);
  localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(SPR_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                vsync_q;
  logic                frame_tick;
  logic [FW-1:0]       frame_q, frame_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [9:0]          pos_x_q, pos_x_d;
  logic [9:0]          pos_y_q, pos_y_d;
  logic                mirror_q, mirror_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic                sprite_on_q, sprite_on_d;

  logic [10:0]         x_end, y_end;
  logic                in_box;
  logic [9:0]          rx, ry, col;

  assign frame_tick = vsync_q & ~vsync;

  // Position and mirror are only taken at the field boundary so a sprite never shears mid-field.
  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    mirror_d = mirror_q;
    if (frame_tick) begin
      pos_x_d  = pos_x;
      pos_y_d  = pos_y;
      mirror_d = mirror;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_PLAY;
          frame_d = '0;
          hold_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (hold_q < HOLD_LAST) begin
            hold_d = hold_q + HW'(1);
          end else begin
            hold_d = '0;
            if (frame_q < FRAME_LAST) begin
              frame_d = frame_q + FW'(1);
            end else if (loop) begin
              frame_d = '0;
            end else begin
              state_d = S_DONE;
              frame_d = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        frame_d = '0;
        hold_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Box edges are formed in 11 bits so a sprite near column/row 1023 clips instead of wrapping.
  always_comb begin
    x_end  = {1'b0, pos_x_q} + 11'(SPR_W);
    y_end  = {1'b0, pos_y_q} + 11'(SPR_H);
    in_box = (draw_x >= pos_x_q) && ({1'b0, draw_x} < x_end) &&
             (draw_y >= pos_y_q) && ({1'b0, draw_y} < y_end);
    rx  = draw_x - pos_x_q;
    ry  = draw_y - pos_y_q;
    col = mirror_q ? (10'(SPR_W - 1) - rx) : rx;
    rom_address_d = '0;
    if (in_box) begin
      rom_address_d = ADDR_W'(frame_q) * FRAME_SIZE + ADDR_W'(ry) * ROW_SIZE + ADDR_W'(col);
    end
    sprite_on_d = in_box;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b1;
      frame_q       <= '0;
      hold_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      mirror_q      <= 1'b0;
      rom_address_q <= '0;
      sprite_on_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync;
      frame_q       <= frame_d;
      hold_q        <= hold_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      mirror_q      <= mirror_d;
      rom_address_q <= rom_address_d;
      sprite_on_q   <= sprite_on_d;
    end
  end

  assign rom_address = rom_address_q;
  assign sprite_on   = sprite_on_q;
  assign frame       = frame_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sprite_addr_seq.sv
// Scoreboard bench for sprite_addr_seq: address expectations are queued by the stimulus
// and popped by a monitor one cycle later; animation sequencing is checked directly.
module tb_sprite_addr_seq;

  logic        vga_clk;
  logic        reset;
  logic        vsync;
  logic [9:0]  draw_x, draw_y, pos_x, pos_y;
  logic        mirror, play, loop;
  logic [15:0] rom_address;
  logic        sprite_on;
  logic [1:0]  frame;
  logic        busy, done;

  typedef struct {
    logic [15:0] addr;
    logic        on;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   passCount  = 0;
  int   checkCount = 0;
  logic issue      = 1'b0;
  logic checkPend  = 1'b0;
  logic doneSeen;

  sprite_addr_seq dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .vsync      (vsync),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .mirror     (mirror),
    .play       (play),
    .loop       (loop),
    .rom_address(rom_address),
    .sprite_on  (sprite_on),
    .frame      (frame),
    .busy       (busy),
    .done       (done)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Every issued pixel produces exactly one registered response one clock later.
  always @(posedge vga_clk) checkPend <= issue;

  always @(negedge vga_clk) begin
    if (checkPend) begin
      if (sbq.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL scoreboard: response with empty queue, addr %0d", rom_address);
      end else begin
        monE = sbq.pop_front();
        checkOutput({monE.name, " addr"}, 32'(rom_address), 32'(monE.addr));
        checkOutput({monE.name, " on"}, 32'(sprite_on), 32'(monE.on));
      end
    end
  end

  task automatic applyStimulus(input string name, input int x, input int y,
                               input int addr, input logic on);
    exp_t e;
    @(negedge vga_clk);
    draw_x = 10'(x);
    draw_y = 10'(y);
    e.addr = 16'(addr);
    e.on   = on;
    e.name = name;
    sbq.push_back(e);
    issue = 1'b1;
    @(negedge vga_clk);
    issue = 1'b0;
  endtask

  task automatic vsyncPulse(output logic doneAfterTick);
    @(negedge vga_clk);
    vsync = 1'b0;
    @(negedge vga_clk);
    doneAfterTick = done;
    @(negedge vga_clk);
    vsync = 1'b1;
    @(negedge vga_clk);
  endtask

  task automatic playPulse();
    @(negedge vga_clk);
    play = 1'b1;
    @(negedge vga_clk);
    play = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passCount, checkCount);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; vsync = 1'b1; play = 1'b0; loop = 1'b0; mirror = 1'b0;
    draw_x = '0; draw_y = '0; pos_x = '0; pos_y = '0;
    repeat (3) @(negedge vga_clk);
    checkOutput("reset addr", 32'(rom_address), 0);
    checkOutput("reset on", 32'(sprite_on), 0);
    checkOutput("reset frame", 32'(frame), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    reset = 1'b0;

    $display("[TB] address path, normal orientation");
    pos_x = 10'd100; pos_y = 10'd50; mirror = 1'b0;
    vsyncPulse(doneSeen);
    applyStimulus("top-left", 100, 50, 0, 1'b1);
    applyStimulus("bottom-right", 195, 161, 10751, 1'b1);
    applyStimulus("right of box", 196, 50, 0, 1'b0);
    applyStimulus("left of box", 99, 50, 0, 1'b0);
    applyStimulus("last row", 100, 161, 10656, 1'b1);
    applyStimulus("below box", 100, 162, 0, 1'b0);

    $display("[TB] address path, mirrored");
    mirror = 1'b1;
    vsyncPulse(doneSeen);
    applyStimulus("mirror left", 100, 50, 95, 1'b1);
    applyStimulus("mirror right", 195, 50, 0, 1'b1);
    applyStimulus("mirror row1", 100, 51, 191, 1'b1);

    $display("[TB] latching and clipping");
    mirror = 1'b0;
    vsyncPulse(doneSeen);
    pos_x = 10'd300;
    applyStimulus("mid-field move", 100, 50, 0, 1'b1);
    vsyncPulse(doneSeen);
    applyStimulus("old pos after tick", 100, 50, 0, 1'b0);
    applyStimulus("new pos after tick", 300, 50, 0, 1'b1);
    pos_x = 10'd600;
    vsyncPulse(doneSeen);
    applyStimulus("far right no wrap", 5, 50, 0, 1'b0);
    pos_x = 10'd1000;
    vsyncPulse(doneSeen);
    applyStimulus("clip inside", 1023, 50, 23, 1'b1);
    applyStimulus("clip no wrap", 4, 50, 0, 1'b0);
    pos_x = 10'd100; pos_y = 10'd1000;
    vsyncPulse(doneSeen);
    applyStimulus("y clip no wrap", 100, 5, 0, 1'b0);
    pos_y = 10'd50;
    vsyncPulse(doneSeen);

    $display("[TB] one-shot animation");
    loop = 1'b0;
    playPulse();
    checkOutput("play busy", 32'(busy), 1);
    checkOutput("play frame", 32'(frame), 0);
    for (int t = 1; t <= 24; t++) begin
      vsyncPulse(doneSeen);
      if (t < 24) begin
        checkOutput($sformatf("oneshot t%0d frame", t), 32'(frame), 32'(t / 6));
        checkOutput($sformatf("oneshot t%0d done", t), 32'(doneSeen), 0);
        checkOutput($sformatf("oneshot t%0d busy", t), 32'(busy), 1);
      end else begin
        checkOutput("end done pulse", 32'(doneSeen), 1);
        checkOutput("end done cleared", 32'(done), 0);
        checkOutput("end frame", 32'(frame), 0);
        checkOutput("end busy", 32'(busy), 0);
      end
      if (t == 3) playPulse();
      if (t == 12) applyStimulus("frame2 addr", 100, 50, 21504, 1'b1);
    end

    $display("[TB] looping animation");
    loop = 1'b1;
    playPulse();
    for (int t = 1; t <= 36; t++) begin
      vsyncPulse(doneSeen);
      checkOutput($sformatf("loop t%0d done", t), 32'(doneSeen), 0);
      if (t == 24) begin
        checkOutput("loop wrap frame", 32'(frame), 0);
        checkOutput("loop wrap busy", 32'(busy), 1);
      end
    end
    checkOutput("loop frame 2", 32'(frame), 2);
    applyStimulus("loop frame2 addr", 100, 50, 21504, 1'b1);

    $display("[TB] asynchronous reset mid-animation");
    @(negedge vga_clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("async addr", 32'(rom_address), 0);
    checkOutput("async on", 32'(sprite_on), 0);
    checkOutput("async frame", 32'(frame), 0);
    checkOutput("async busy", 32'(busy), 0);
    checkOutput("async done", 32'(done), 0);
    @(negedge vga_clk);
    reset = 1'b0;

    $display("[TB] play and tick in the same cycle");
    loop = 1'b0;
    @(negedge vga_clk);
    play = 1'b1; vsync = 1'b0;
    @(negedge vga_clk);
    play = 1'b0;
    @(negedge vga_clk);
    vsync = 1'b1;
    @(negedge vga_clk);
    checkOutput("same-cycle busy", 32'(busy), 1);
    repeat (5) vsyncPulse(doneSeen);
    checkOutput("same-cycle hold", 32'(frame), 0);
    vsyncPulse(doneSeen);
    checkOutput("same-cycle step", 32'(frame), 1);

    repeat (2) @(negedge vga_clk);
    if (sbq.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
